// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// Latency: Done WIDTH+1 cycles after the Start cycle (1 cycle for divide-by-zero).
// Stall is raised only in RUN, when the pipeline touches HI/LO or issues another op.
// Ports: Clk/Rst (async active-low); Start/Op/A/B issue; Flush abort; ReadHiLo/WriteHi/
//        WriteLo/WrData for MFHI/MFLO/MTHI/MTLO; Busy/Stall/Done status; Hi/Lo registers.
// Optional: `define MULDIV_EARLY_TERM_EN finishes a multiply once the remaining
//           multiplier bits are all zero.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  input  logic             ReadHiLo,
  input  logic             WriteHi,
  input  logic             WriteLo,
  input  logic [WIDTH-1:0] WrData,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             is_div, neg_q, neg_r;
  // opnd holds the multiplicand or divisor magnitude; work_hi/work_lo form the
  // shifting accumulator pair (product halves, or remainder/quotient).
  logic [WIDTH-1:0] opnd, work_hi, work_lo, hi_q, lo_q;

  // Issue decode
  logic             start_ok, div_zero, is_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign start_ok  = Start & ~Flush & (state != S_RUN);
  assign div_zero  = Op[1] & (B == '0);
  assign is_signed = ~Op[0];
  assign a_neg     = is_signed & A[WIDTH-1];
  assign b_neg     = is_signed & B[WIDTH-1];
  assign a_mag     = a_neg ? -A : A;
  assign b_mag     = b_neg ? -B : B;

  // One iteration of the shared datapath
  logic [WIDTH:0]   mul_sum, div_trial;
  logic [WIDTH-1:0] it_hi, it_lo;

  always_comb begin
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : '0);
    // Partial remainder is always below the divisor, so the (WIDTH+1)-bit
    // difference's top bit is a clean borrow flag.
    div_trial = {work_hi, work_lo[WIDTH-1]} - {1'b0, opnd};
    it_hi     = mul_sum[WIDTH:1];
    it_lo     = {mul_sum[0], work_lo[WIDTH-1:1]};
    if (is_div) begin
      if (div_trial[WIDTH]) begin
        it_hi = {work_hi[WIDTH-2:0], work_lo[WIDTH-1]};
        it_lo = {work_lo[WIDTH-2:0], 1'b0};
      end else begin
        it_hi = div_trial[WIDTH-1:0];
        it_lo = {work_lo[WIDTH-2:0], 1'b1};
      end
    end
  end

  logic               last_iter, finish;
  logic [2*WIDTH-1:0] prod_al, prod_fin;
  logic [WIDTH-1:0]   quo_fin, rem_fin;

  assign last_iter = (cnt == CW'(1));

`ifdef MULDIV_EARLY_TERM_EN
  // The low 'remain' bits of it_lo are the multiplier bits not yet consumed;
  // once they are all zero every later step is a plain shift, done here at once.
  logic [CW-1:0]    remain;
  logic [WIDTH-1:0] pend_mask;
  assign remain    = cnt - CW'(1);
  assign pend_mask = ~({WIDTH{1'b1}} << remain);
  assign finish    = last_iter | (~is_div & ((it_lo & pend_mask) == '0));
  assign prod_al   = {it_hi, it_lo} >> remain;
`else
  assign finish    = last_iter;
  assign prod_al   = {it_hi, it_lo};
`endif

  assign prod_fin = neg_q ? -prod_al : prod_al;
  assign quo_fin  = neg_q ? -it_lo : it_lo;
  assign rem_fin  = neg_r ? -it_hi : it_hi;

  // FSM
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_RUN: begin
        if (Flush)       state_nxt = S_IDLE;
        else if (finish) state_nxt = S_DONE;
        else             state_nxt = S_RUN;
      end
      default: begin
        if (start_ok) state_nxt = div_zero ? S_DONE : S_RUN;
      end
    endcase
  end

  // Datapath and HI/LO
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      opnd    <= '0;
      work_hi <= '0;
      work_lo <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (state == S_RUN) begin
      // MT* and Start are stalled here and have no effect.
      if (!Flush) begin
        cnt     <= cnt - CW'(1);
        work_hi <= it_hi;
        work_lo <= it_lo;
        if (finish) begin
          if (is_div) begin
            hi_q <= rem_fin;
            lo_q <= quo_fin;
          end else begin
            hi_q <= prod_fin[2*WIDTH-1:WIDTH];
            lo_q <= prod_fin[WIDTH-1:0];
          end
        end
      end
    end else begin
      if (start_ok) begin
        is_div  <= Op[1];
        neg_q   <= a_neg ^ b_neg;
        neg_r   <= a_neg;
        cnt     <= CW'(WIDTH);
        work_hi <= '0;
        opnd    <= Op[1] ? b_mag : a_mag;
        work_lo <= Op[1] ? a_mag : b_mag;
      end
      if (start_ok & div_zero) begin
        hi_q <= A;
        lo_q <= '1;
      end else begin
        if (WriteHi) hi_q <= WrData;
        if (WriteLo) lo_q <= WrData;
      end
    end
  end

  assign Busy  = (state == S_RUN);
  assign Done  = (state == S_DONE);
  assign Stall = (state == S_RUN) & (ReadHiLo | Start | WriteHi | WriteLo);
  assign Hi    = hi_q;
  assign Lo    = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: table-driven and scoreboarded checks of muldiv_sequencer,
// plus hand-written sequences for stall, back-to-back issue, MT* during RUN,
// flush and mid-operation reset.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Rst, Start, Flush, ReadHiLo, WriteHi, WriteLo;
  logic [1:0]   Op;
  logic [W-1:0] A, B, WrData;
  logic         Busy, Stall, Done;
  logic [W-1:0] Hi, Lo;

  always #5 Clk = ~Clk;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .Flush(Flush), .ReadHiLo(ReadHiLo), .WriteHi(WriteHi), .WriteLo(WriteLo),
    .WrData(WrData), .Busy(Busy), .Stall(Stall), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  vec_t vec[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference result {hi, lo}
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = '0;
    case (op)
      2'b00: res = sa * sb;
      2'b01: res = ua * ub;
      default: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else if (op == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end else begin
          res = {ua[31:0] % ub[31:0], ua[31:0] / ub[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Cycles from the Start cycle to the Done cycle
  function automatic int lat_of(input logic [1:0] op, input logic [31:0] b);
    if (op[1] && b == 32'd0) return 1;
`ifdef MULDIV_EARLY_TERM_EN
    if (!op[1]) begin
      logic [31:0] mb;
      int          msb;
      mb  = (op == 2'b00 && b[31]) ? -b : b;
      msb = 0;
      for (int i = 0; i < 32; i++) if (mb[i]) msb = i;
      return 2 + msb;
    end
`endif
    return 33;
  endfunction

  task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    Op = op; A = a; B = b; Start = 1'b1;
    e.hi = hi; e.lo = lo; e.lat = lat_of(op, b);
    sb_q.push_back(e);
  endtask

  task automatic compare_done(input string nm, input int n);
    exp_t e;
    chk({nm, "_done"}, 64'(Done), 64'd1);
    if (sb_q.size() == 0) begin
      chk({nm, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      chk({nm, "_lat"}, 64'(n), 64'(e.lat));
      chk({nm, "_hi"}, 64'(Hi), 64'(e.hi));
      chk({nm, "_lo"}, 64'(Lo), 64'(e.lo));
    end
  endtask

  // Current cycle is n0 cycles after the Start cycle; wait (bounded) for Done.
  task automatic wait_done(input string nm, input int n0);
    int n;
    n = n0;
    while (!Done && n < 100) begin
      tick();
      n++;
    end
    compare_done(nm, n);
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo, input string nm);
    drive_start(op, a, b, hi, lo);
    tick();
    Start = 1'b0;
    wait_done(nm, 1);
  endtask

  initial begin
    int          n, stall_n, busy_n;
    logic        seen;
    logic [63:0] r;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    vec[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vec[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vec[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vec[3]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vec[4]  = '{2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};
    vec[5]  = '{2'b01, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 32'h0000_000F};
    vec[6]  = '{2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vec[7]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vec[8]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vec[9]  = '{2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};
    vec[10] = '{2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vec[11] = '{2'b01, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vec[12] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};

    Rst = 1'b0; Start = 1'b0; Flush = 1'b0; ReadHiLo = 1'b1;
    WriteHi = 1'b0; WriteLo = 1'b0; Op = 2'b00; A = '0; B = '0; WrData = '0;

    // Reset state
    tick();
    tick();
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_stall", 64'(Stall), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_hi", 64'(Hi), 64'd0);
    chk("rst_lo", 64'(Lo), 64'd0);
    ReadHiLo = 1'b0;
    Rst = 1'b1;
    tick();

    // Table vectors, issued back to back from the DONE cycle
    for (int i = 0; i < 13; i++)
      do_op(vec[i].op, vec[i].a, vec[i].b, vec[i].hi, vec[i].lo, $sformatf("vec%0d", i));
    tick();

    // Random vectors against the reference model
    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 5 == 0) ? 32'd0 : ((i % 4 == 1) ? 32'($urandom_range(1, 15)) : $urandom);
      r   = model(rop, ra, rb);
      do_op(rop, ra, rb, r[63:32], r[31:0], $sformatf("rnd%0d", i));
    end
    tick();

    // Stall while ReadHiLo is held; a Start during RUN is ignored
    ReadHiLo = 1'b1;
    drive_start(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    tick();
    Start = 1'b0;
    n = 1; stall_n = 0; busy_n = 0;
    while (!Done && n < 100) begin
      if (Stall) stall_n++;
      if (Busy) busy_n++;
      if (n == 3) begin
        Op = 2'b01; A = 32'd2; B = 32'd2; Start = 1'b1;
      end else begin
        Start = 1'b0;
      end
      tick();
      n++;
    end
    Start = 1'b0;
    chk("stall_in_done", 64'(Stall), 64'd0);
    chk("stall_cycles", 64'(stall_n), 64'd32);
    chk("busy_cycles", 64'(busy_n), 64'd32);
    compare_done("ignored_start", n);
    ReadHiLo = 1'b0;

    // Back-to-back Start in the DONE cycle
    do_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, "b2b");

    // MTLO during RUN: stalled, no effect
    drive_start(2'b01, 32'd3, 32'h8000_0004, 32'h0000_0001, 32'h8000_000C);
    tick();
    Start = 1'b0;
    tick();
    WriteLo = 1'b1; WrData = 32'hAA;
    #1;
    chk("mtlo_run_stall", 64'(Stall), 64'd1);
    tick();
    WriteLo = 1'b0;
    chk("mtlo_run_lo", 64'(Lo), 64'd42);
    wait_done("mtlo_run", 3);

    // MTHI/MTLO in IDLE
    tick();
    WriteHi = 1'b1; WrData = 32'h55;
    #1;
    chk("mthi_idle_stall", 64'(Stall), 64'd0);
    tick();
    WriteHi = 1'b0;
    chk("mthi_idle_hi", 64'(Hi), 64'h55);
    WriteLo = 1'b1; WrData = 32'h66;
    tick();
    WriteLo = 1'b0;
    chk("mtlo_idle_lo", 64'(Lo), 64'h66);

    // Flush at iteration 5
    Op = 2'b11; A = 32'd100; B = 32'd7; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (4) tick();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    chk("flush_busy", 64'(Busy), 64'd0);
    chk("flush_hi", 64'(Hi), 64'h55);
    chk("flush_lo", 64'(Lo), 64'h66);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (Done) seen = 1'b1;
    end
    chk("flush_no_done", 64'(seen), 64'd0);

    // Flush with Start in IDLE: Start ignored
    Op = 2'b11; A = 32'd9; B = 32'd0; Start = 1'b1; Flush = 1'b1;
    tick();
    Start = 1'b0; Flush = 1'b0;
    chk("flush_start_done", 64'(Done), 64'd0);
    chk("flush_start_busy", 64'(Busy), 64'd0);
    chk("flush_start_hi", 64'(Hi), 64'h55);

    // Asynchronous reset at iteration 10
    Op = 2'b01; A = 32'd5; B = 32'h8000_0001; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (9) tick();
    #2;
    Rst = 1'b0;
    #1;
    chk("midrst_busy", 64'(Busy), 64'd0);
    chk("midrst_done", 64'(Done), 64'd0);
    chk("midrst_hi", 64'(Hi), 64'd0);
    chk("midrst_lo", 64'(Lo), 64'd0);
    tick();
    Rst = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (Done) seen = 1'b1;
    end
    chk("midrst_no_done", 64'(seen), 64'd0);

    do_op(2'b01, 32'd5, 32'd3, 32'd0, 32'd15, "post_rst");
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative multiply/divide controller for the pipelined MIPS datapath. Accepts MULT, MULTU, DIV and DIVU from the EX stage and sequences a shared radix-2 shift/add (multiply) or restoring (divide) datapath over WIDTH cycles. Owns the HI/LO architectural registers and handles MTHI/MTLO writes. Raises Stall to the hazard unit while HI/LO are not yet valid.

Parameters:
WIDTH, 32, operand width; one iteration per bit.

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  asynchronous active-low reset
Start  input  1  EX-stage mult/div issue strobe
Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start
A  input  WIDTH  rs operand (multiplicand/dividend); sampled with Start
B  input  WIDTH  rt operand (multiplier/divisor); sampled with Start
Flush  input  1  abort in-flight operation (branch/jump squash of the issuing instruction)
ReadHiLo  input  1  ID/EX holds MFHI/MFLO
WriteHi  input  1  MTHI strobe
WriteLo  input  1  MTLO strobe
WrData  input  WIDTH  MTHI/MTLO data
Busy  output  1  high in RUN
Stall  output  1  pipeline stall request
Done  output  1  one-cycle pulse; HI/LO updated this cycle
Hi  output  WIDTH  HI register
Lo  output  WIDTH  LO register

Behaviour:
- Reset (Rst low, asynchronous): state IDLE; Hi=0, Lo=0, Busy=0, Stall=0, Done=0; iteration counter and internal working registers cleared. Reset mid-operation discards the operation.
- States: IDLE, RUN, DONE.
- IDLE/DONE with Start=1: latch Op, A and B; for signed ops, latch |A|, |B| and sign flags; counter=WIDTH; go to RUN. In IDLE/DONE with Start=0, go to IDLE.
- RUN: one iteration per cycle; counter decrements; at counter==1, write final Hi/Lo and go to DONE.
- Latency: Done is high exactly WIDTH+1 cycles after the edge that samples Start, and Hi/Lo hold the new values in that same cycle.
- Multiply: unsigned 2*WIDTH product, Hi = upper half, Lo = lower half. For MULT, the product is two's-complement negated when the operand signs differ.
- Divide: unsigned restoring division on magnitudes, Lo = quotient, Hi = remainder. For DIV, the quotient is negated when the signs differ and the remainder takes the sign of the dividend. 0x80000000 / -1 gives Lo=0x80000000, Hi=0.
- Divide by zero (B==0 at Start): skip RUN and go straight to DONE the next cycle (Done 1 cycle after Start). Result is Lo=all ones, Hi=A unmodified.
- Stall = (state==RUN) & (ReadHiLo | Start | WriteHi | WriteLo). Stall is never asserted in IDLE or DONE.
- A Start seen during RUN is ignored; the issuer is held by Stall and re-presents it.
- MTHI/MTLO: in IDLE/DONE, WriteHi/WriteLo update Hi/Lo at the next edge. In RUN they stall and have no effect.
- Simultaneous DONE writeback and MT* in the same cycle: the DONE result wins. MT* writes are accepted only in IDLE/DONE, and the DONE writeback happens on the RUN->DONE edge, so the two never collide.
- Flush in RUN: return to IDLE at the next edge, Hi/Lo unchanged, no Done. Flush in IDLE/DONE with Start=1: Start is ignored.
- Busy = (state==RUN).
- Done = (state==DONE) and is registered.

Optional Feature:
MULDIV_EARLY_TERM_EN
- Defined: in a multiply, once the remaining unshifted multiplier bits are all zero, the product is aligned in one step and the FSM goes to DONE on the next cycle. Latency is then 2 + (index of the highest set bit of |B|) cycles, minimum 2. Division timing is unchanged.
- Undefined: fixed WIDTH+1 latency for all non-zero-divisor ops.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Done at cycle 33, Hi=0xFFFFFFFE, Lo=0x00000001. Busy is high for 32 cycles.
- MULT A=-3, B=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- DIV A=-7, B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIV A=0x80000000, B=-1 -> Lo=0x80000000, Hi=0.
- DIVU A=0x1234, B=0 -> Done 1 cycle after Start, Lo=0xFFFFFFFF, Hi=0x1234.
- ReadHiLo held high from Start until Done -> Stall high for 32 cycles and low in the Done cycle. A second Start in RUN is ignored; a back-to-back Start in the DONE cycle is accepted.
- MTLO 0xAA during RUN -> stalled, Lo unchanged.
- Rst low at iteration 10 -> IDLE immediately, Hi=Lo=0, no Done.
- Flush at iteration 5 -> IDLE with prior Hi/Lo kept.
- With MULDIV_EARLY_TERM_EN: MULTU A=5, B=3 -> Done 3 cycles after Start, Lo=15.
